// File: rtl/i2c_addr_translator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_addr_translator
//
// Inline, passive I2C address translator for a shared open-drain SCL/SDA
// segment. It follows every transaction, decodes the 7-bit address phase and,
// when the master addresses VIRT_ADDR, pulls the differing address bits low
// while they are on the wire. The downstream target therefore sees PHYS_ADDR.
// All other traffic passes through untouched.
//
// Parameters
//   VIRT_ADDR  address the master uses (default 7'h49)
//   PHYS_ADDR  address the targets see (default 7'h48). Because the block
//              can only clear bits, PHYS_ADDR & ~VIRT_ADDR must be zero.
//
// Ports
//   clk     system clock, at least 8x the SCL rate
//   reset   asynchronous, active-low reset
//   enable  1 = translation active, 0 = fully passive (FSM held in IDLE)
//   scl     I2C clock, open-drain; this block only ever releases it
//   sda     I2C data, open-drain; driven 0 or released (Z)
//
// Internal drive registers (may be probed/forced by verification):
//   scl_driver, sda_driver: 1 = pull line low, 0 = release
//
// Build option
//   I2C_XLATE_GLITCH_FILTER_EN: adds a 3-sample majority filter after each
//   synchronizer. Pulses shorter than 2 clk are rejected, drive latency
//   grows from 3 to 5 clk and SCL low time must exceed 6 clk.
// ---------------------------------------------------------------------------
module i2c_addr_translator #(
  parameter logic [6:0] VIRT_ADDR = 7'h49,
  parameter logic [6:0] PHYS_ADDR = 7'h48
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  inout  wire  scl,
  inout  wire  sda
);

  // Address bits that must be pulled low to turn VIRT_ADDR into PHYS_ADDR.
  localparam logic [6:0] XLATE_MASK = VIRT_ADDR ^ PHYS_ADDR;

  typedef enum logic [1:0] {
    ST_IDLE,  // waiting for START
    ST_ADDR,  // shifting in A6..A0 and R/W
    ST_ACK,   // ninth clock of the address byte
    ST_PASS   // data bytes, ignored until START/STOP
  } state_t;

  state_t     state, state_d;
  logic [3:0] bit_cnt, bit_cnt_d;   // address bits received (0..9)
  logic       match, match_d;       // bits received so far equal VIRT_ADDR
  logic       sda_driver, sda_driver_d;
  logic       scl_driver;

  // -------------------------------------------------------------------------
  // Input synchronization: index 1 = scl, index 0 = sda.
  // -------------------------------------------------------------------------
  logic [1:0] pin_meta, pin_sync;
  logic [1:0] line_now, line_prev;

  // NOTE: the synchronizer and history flops reset to 1 (idle bus) rather
  // than 0, so leaving reset never looks like an SDA fall with SCL high,
  // which would be decoded as a phantom START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin_meta <= 2'b11;
      pin_sync <= 2'b11;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour; blocking here would
      // collapse the two synchronizer stages into one.
      pin_meta <= {scl, sda};
      pin_sync <= pin_meta;
    end
  end

`ifdef I2C_XLATE_GLITCH_FILTER_EN
  logic [1:0] filt_s0, filt_s1, filt_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_s0 <= 2'b11;
      filt_s1 <= 2'b11;
      filt_s2 <= 2'b11;
    end else begin
      filt_s0 <= pin_sync;
      filt_s1 <= filt_s0;
      filt_s2 <= filt_s1;
    end
  end

  // Bitwise 2-of-3 majority: a value must persist for two samples to pass.
  assign line_now = (filt_s0 & filt_s1) | (filt_s1 & filt_s2) |
                    (filt_s0 & filt_s2);
`else
  assign line_now = pin_sync;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_prev <= 2'b11;
    end else begin
      line_prev <= line_now;
    end
  end

  // -------------------------------------------------------------------------
  // Bus event detection on the synchronized lines.
  // -------------------------------------------------------------------------
  logic scl_now, scl_prev, sda_now, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_now  = line_now[1];
  assign sda_now  = line_now[0];
  assign scl_prev = line_prev[1];
  assign sda_prev = line_prev[0];

  assign scl_rise  =  scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now &  scl_prev;
  assign start_det =  scl_now &  scl_prev &  sda_prev & ~sda_now;
  assign stop_det  =  scl_now &  scl_prev & ~sda_prev &  sda_now;

  // Index of the address bit whose window follows the current count:
  // with bit_cnt bits received, the next bit on the wire is A(6-bit_cnt).
  logic [2:0] bit_idx;
  assign bit_idx = 3'd6 - bit_cnt[2:0];

  // -------------------------------------------------------------------------
  // FSM next-state and drive decision.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default first; a path that
    // left one unassigned would infer a latch.
    state_d      = state;
    bit_cnt_d    = bit_cnt;
    match_d      = match;
    sda_driver_d = sda_driver;

    if (!enable) begin
      state_d      = ST_IDLE;
      bit_cnt_d    = 4'd0;
      sda_driver_d = 1'b0;
    end else if (start_det) begin
      // START or repeated START: restart address capture from A6.
      state_d      = ST_ADDR;
      bit_cnt_d    = 4'd0;
      match_d      = 1'b1;
      sda_driver_d = 1'b0;
    end else if (stop_det) begin
      state_d      = ST_IDLE;
      bit_cnt_d    = 4'd0;
      sda_driver_d = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          sda_driver_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            if (bit_cnt < 4'd7) begin
              // While this block pulls the bit low the master's own value is
              // hidden; it is assumed to be the virtual bit, so a pulled bit
              // never breaks the match for later bits.
              match_d = match & ((sda_now == VIRT_ADDR[bit_idx]) | sda_driver);
            end
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state_d = ST_ADDR == state ? ST_ACK : state;
            end
          end else if (scl_fall) begin
            // SCL fall opens the low window of the next bit: decide whether
            // to hold SDA low for that whole bit. R/W is never touched.
            if (bit_cnt < 4'd7) begin
              sda_driver_d = XLATE_MASK[bit_idx] & match;
            end else begin
              sda_driver_d = 1'b0;
            end
          end
        end

        ST_ACK: begin
          sda_driver_d = 1'b0;
          if (scl_rise) begin
            bit_cnt_d = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            state_d   = ST_PASS;
            bit_cnt_d = 4'd0;
          end
        end

        ST_PASS: begin
          sda_driver_d = 1'b0;
        end

        default: begin
          state_d      = ST_IDLE;
          bit_cnt_d    = 4'd0;
          sda_driver_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      match      <= 1'b0;
      sda_driver <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      match      <= match_d;
      sda_driver <= sda_driver_d;
    end
  end

  // SCL is never stretched; the register exists so the pin structure is
  // symmetric with SDA and can be forced during verification.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_driver <= 1'b0;
    end else begin
      scl_driver <= 1'b0;
    end
  end

  // Open-drain pads: pull low or release.
  assign scl = scl_driver ? 1'b0 : 1'bz;
  assign sda = sda_driver ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_addr_translator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_addr_translator
//
// A bench-side I2C master drives directed address phases onto a pulled-up
// open-drain bus shared with the translator. Each address phase pushes its
// hand-computed expectation into a queue. An independent bus monitor decodes
// every START + 9 clocks from the wires, samples the drive register in each
// bit window, pops the queue and compares.
//
// Per-window samples (bit 8 = A6 window ... bit 2 = A0, bit 1 = R/W,
// bit 0 = ACK slot):
//   early: sda_driver 21 ns after SCL fall (before the 3-clk update)
//   late : sda_driver 29 ns after SCL fall (after the 3-clk update)
//   high : sda_driver 1 ns after SCL rise
//   bus  : sda line 1 ns after SCL rise
// ---------------------------------------------------------------------------
module tb_i2c_addr_translator;

  localparam logic [6:0] VIRT = 7'h49;
  localparam logic [6:0] PHYS = 7'h48;

  // Translated address phase: pull starts at the A0 window, ends in R/W.
  localparam logic [8:0] XL_EARLY = 9'h002;
  localparam logic [8:0] XL_LATE  = 9'h004;
  localparam logic [8:0] XL_HIGH  = 9'h004;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic m_scl_low;
  logic m_sda_low;

  wire scl;
  wire sda;

  pullup pu_scl (scl);
  pullup pu_sda (sda);

  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_addr_translator #(
    .VIRT_ADDR(VIRT),
    .PHYS_ADDR(PHYS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .scl    (scl),
    .sda    (sda)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [8:0] bus;
    logic [8:0] early;
    logic [8:0] late;
    logic [8:0] high;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;
  int   drive_cycles = 0;

  // Counts clocks with SDA pulled, sampled away from the active edge.
  always @(negedge clk) begin
    if (dut.sda_driver === 1'b1) drive_cycles <= drive_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input logic [8:0] bus, input logic [8:0] early,
                            input logic [8:0] late, input logic [8:0] high);
    exp_t e;
    e.id    = txn_id;
    e.bus   = bus;
    e.early = early;
    e.late  = late;
    e.high  = high;
    txn_id++;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------
  // Bus monitor / scoreboard
  // ---------------------------------------------------------------------
  initial begin : monitor
    exp_t       e;
    logic [8:0] bus, early, late, high;
    forever begin
      @(negedge sda);
      if (scl === 1'b1) begin
        for (int p = 0; p < 9; p++) begin
          @(negedge scl);
          #21 early[8-p] = dut.sda_driver;
          #8  late[8-p]  = dut.sda_driver;
          @(posedge scl);
          #1;
          bus[8-p]  = sda;
          high[8-p] = dut.sda_driver;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got bus 0x%0h, expected no transaction", bus);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("txn%0d_bus", e.id),   bus,   e.bus);
          check($sformatf("txn%0d_early", e.id), early, e.early);
          check($sformatf("txn%0d_late", e.id),  late,  e.late);
          check($sformatf("txn%0d_high", e.id),  high,  e.high);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bench master. Bit windows: 80 ns SCL low, 80 ns SCL high; the master
  // changes SDA 40 ns into the low phase. act 1 = drop enable, act 2 =
  // reset pulse, both 32 ns into the low phase.
  // ---------------------------------------------------------------------
  task automatic bit_out(input logic b, input int act);
    #32;
    if (act == 1) begin
      enable = 1'b0;
      #4 check("enable_drop_release", dut.sda_driver, 1'b0);
      #4;
    end else if (act == 2) begin
      reset = 1'b0;
      #1 check("reset_sda_release", dut.sda_driver, 1'b0);
      check("reset_scl_driver", dut.scl_driver, 1'b0);
      #7 reset = 1'b1;
    end else begin
      #8;
    end
    m_sda_low = ~b;
    #40 m_scl_low = 1'b0;
    #80 m_scl_low = 1'b1;
  endtask

  // Eight bits MSB first plus a released ninth (ACK) slot.
  task automatic byte_out(input logic [7:0] b, input int act_bit, input int act);
    for (int i = 7; i >= 0; i--) begin
      bit_out(b[i], (i == act_bit) ? act : 0);
    end
    bit_out(1'b1, 0);
  endtask

  task automatic start_cond();
    #40 m_sda_low = 1'b1;
    #40 m_scl_low = 1'b1;
  endtask

  task automatic rstart_cond();
    #40 m_sda_low = 1'b0;
    #40 m_scl_low = 1'b0;
    #40 m_sda_low = 1'b1;
    #40 m_scl_low = 1'b1;
  endtask

  task automatic stop_cond();
    #40 m_sda_low = 1'b1;
    #40 m_scl_low = 1'b0;
    #40 m_sda_low = 1'b0;
    #80;
  endtask

  task automatic simple_txn(input string name, input logic [7:0] b,
                            input logic [8:0] bus, input logic xl,
                            input int cycles);
    int c0;
    c0 = drive_cycles;
    if (xl) expect_txn(bus, XL_EARLY, XL_LATE, XL_HIGH);
    else    expect_txn(bus, 9'h000, 9'h000, 9'h000);
    start_cond();
    byte_out(b, 0, 0);
    stop_cond();
    #20 check({name, "_drive_cycles"}, drive_cycles - c0, cycles);
  endtask

  initial begin : stimulus
    int c0;
    reset     = 1'b0;
    enable    = 1'b1;
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    #100 reset = 1'b1;
    #50;
    check("reset_sda_driver", dut.sda_driver, 1'b0);
    check("reset_scl_driver_idle", dut.scl_driver, 1'b0);
    check("reset_scl_line", scl, 1'b1);
    check("reset_sda_line", sda, 1'b1);

    // 0x49 W followed by a data byte of zeros: A0 pulled, bus sees 0x48.
    c0 = drive_cycles;
    expect_txn(9'h121, XL_EARLY, XL_LATE, XL_HIGH);
    start_cond();
    byte_out(8'h92, 0, 0);
    byte_out(8'h00, 0, 0);
    stop_cond();
    #20 check("virt_w_drive_cycles", drive_cycles - c0, 16);

    // 0x48 R: pulled although already 0; R/W stays 1.
    simple_txn("phys_r", 8'h91, 9'h123, 1'b1, 16);

    // 0x1A W: unrelated target, bus untouched.
    simple_txn("other_w", 8'h34, 9'h069, 1'b0, 0);

    // enable=0: 0x49 reaches the bus unchanged.
    enable = 1'b0;
    simple_txn("disabled", 8'h92, 9'h125, 1'b0, 0);
    enable = 1'b1;

    // enable dropped inside the A0 window: released before SCL rises.
    c0 = drive_cycles;
    expect_txn(9'h125, 9'h000, XL_LATE, 9'h000);
    start_cond();
    byte_out(8'h92, 1, 1);
    stop_cond();
    #20 check("enable_drop_drive_cycles", drive_cycles - c0, 1);
    enable = 1'b1;

    // Repeated START: both address phases translated.
    c0 = drive_cycles;
    expect_txn(9'h121, XL_EARLY, XL_LATE, XL_HIGH);
    expect_txn(9'h123, XL_EARLY, XL_LATE, XL_HIGH);
    start_cond();
    byte_out(8'h92, 0, 0);
    rstart_cond();
    byte_out(8'h93, 0, 0);
    stop_cond();
    #20 check("rstart_drive_cycles", drive_cycles - c0, 32);

    // Reset pulse inside the A0 window: released at once, rest untranslated.
    c0 = drive_cycles;
    expect_txn(9'h125, 9'h000, XL_LATE, 9'h000);
    start_cond();
    byte_out(8'h92, 1, 2);
    stop_cond();
    #20 check("reset_mid_drive_cycles", drive_cycles - c0, 1);

    // Next START after the reset is translated again.
    simple_txn("after_reset", 8'h92, 9'h121, 1'b1, 16);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_scl_driver", dut.scl_driver, 1'b0);
    check("final_sda_line", sda, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_addr_translator.md
# i2c_addr_translator

Inline I2C address translator attached to a shared open-drain SCL/SDA bus. It monitors every transaction, decodes the 7-bit address phase and, when the master addresses the virtual address, pulls selected address bits low on the fly so the downstream target sees the physical address. It is purely passive for all other traffic. It sits on the board-level I2C segment between a master and targets whose addresses collide.

## Interface
- VIRT_ADDR, 7'h49: virtual address issued by the master.
- PHYS_ADDR, 7'h48: physical address presented to targets. Required: PHYS_ADDR & ~VIRT_ADDR == 0, because open-drain can only clear bits.
- clk  input  1  system clock, at least 8x the SCL rate.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = translation active; 0 = fully passive.
- scl  inout  1  I2C clock, open-drain. The block only ever releases it (driven Z).
- sda  inout  1  I2C data, open-drain: 0 or Z.
- Internal registers scl_driver and sda_driver: 1 = pull line low, 0 = release (Z). Verification may probe or force them.

## Operation
- scl and sda each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. A repeated START restarts address capture.
- FSM states and transitions:
  - IDLE -> ADDR on START.
  - ADDR: on each SCL rise, sample 8 bits, MSB first: A6..A0, then R/W. After the 8th bit -> ACK.
  - ACK: after the ninth SCL rise and the following SCL fall -> PASS.
  - PASS: ignores data bytes. STOP -> IDLE; START -> ADDR.
- Translation mask: M = VIRT_ADDR ^ PHYS_ADDR.
- For each address bit k with M[k]=1, sda_driver is set for the whole bit-k SCL-low/high window when all address bits already received (A6..A(k+1)) equal VIRT_ADDR. With the defaults, the first six bits 100100 cause bit 0 to be pulled low.
- If the master already sends 0 in that bit, the pull is harmless.
- Never drives during the R/W bit, the ACK slot, data bytes, START, or STOP. scl_driver stays 0 always.
- enable=0: sda_driver is cleared on the next clk and the FSM goes to IDLE. It resumes at the next START seen with enable=1.
- Outputs: scl = scl_driver ? 0 : Z; sda = sda_driver ? 0 : Z.

## Timing
- Reset (reset=0): sda_driver=0, scl_driver=0, FSM=IDLE, bit counter=0, both lines released.
- sda_driver asserts 3 clk after the pin-level SCL fall that ends bit k+1. This is 2 synchronizer cycles plus 1 register cycle.
- sda_driver deasserts 3 clk after the pin-level SCL fall that ends bit k. The release therefore always happens while SCL is low and can never form a STOP.
- The SCL low time must exceed 4 clk so that the pull settles before SCL rises.
- Reset mid-transaction: lines are released immediately (asynchronously). The block then waits in IDLE for a new START, and the remainder of the current transaction passes untranslated.
- A STOP or START seen in any state aborts the current state and releases sda_driver on the next clk.

## Configuration
- I2C_XLATE_GLITCH_FILTER_EN defined: a 3-sample majority filter follows each synchronizer. It rejects pulses shorter than 2 clk. Drive assert/deassert latency becomes 5 clk, and the minimum SCL low time becomes 6 clk.
- Undefined: plain 2-flop synchronizer with the latencies stated above.

## Test plan
- Reset low 100 ns then high, bus idle -> sda_driver=0, scl_driver=0, both lines read 1.
- START, address 0x49, W, ACK slot released, STOP:
  - sda reads 0 during the bit-0 SCL-high window, so the captured address is 0x48.
  - sda_driver is asserted only within bit 0.
- START, address 0x48, R, STOP -> sda_driver asserted in bit 0 (line already low), captured address 0x48, R/W=1 unaffected.
- START, address 0x1A, W, STOP -> sda_driver never asserts; bus is identical to the master's waveform.
- Address 0x49 with enable=0 -> no drive, bus carries 0x49. Dropping enable mid-bit-0 releases SDA within 1 clk.
- Repeated START after the 0x49 address phase, followed by a new 0x49 -> translated again.
- A mid-byte reset pulse releases SDA immediately; the next address passes untranslated until the following START.
